divider32fp: RTL and testbench

Sequential IEEE-754 single-precision divider (quotient = a_i / b_i), the inverse-operation companion of multiplier32FP. It uses the same start/done handshake and the same flag set, so the same bench harness and vector-file flow drive both blocks. The mantissa quotient is computed by iterative restoring division, one bit per clock. Results are rounded to nearest-even, with flush-to-zero on subnormals.

---
 rtl/divider32fp_pkg.sv | 26 ++
 rtl/divider32fp_if.sv | 22 ++
 rtl/divider32fp_mant_divider.sv | 52 +++++
 rtl/divider32fp.sv | 144 ++++++++++++++
 tb/tb_divider32fp.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/divider32fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP divider/multiplier pair.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;
    localparam int ITER     = 25;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2,
        ROUND = 2'd3
    } state_t;

endpackage

// File: rtl/divider32fp_if.sv
// Request/result bundle shared by the FP divider and its driver.
interface divider32fp_if;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        done_o;
    logic        nan_o;
    logic        infinit_o;
    logic        overflow_o;
    logic        underflow_o;
    logic [31:0] quotient_o;

    modport slave (
        input  start_i, a_i, b_i,
        output done_o, nan_o, infinit_o, overflow_o, underflow_o, quotient_o
    );

    modport master (
        output start_i, a_i, b_i,
        input  done_o, nan_o, infinit_o, overflow_o, underflow_o, quotient_o
    );
endinterface

// File: rtl/divider32fp_mant_divider.sv
// Restoring significand divider: one quotient bit per clock, ITER bits total.
module fp32_mant_divider
    import fp32_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [25:0]   i_dividend,
    input  logic [23:0]   i_divisor,
    output logic [24:0]   o_quotient,
    output logic          o_sticky,
    output logic          o_busy,
    output logic          o_last
);
    logic [25:0] r_rem;
    logic [23:0] r_div;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic [26:0] w_diff;

    // remainder stays below 2*divisor, so 26 bits plus a borrow bit suffice
    assign w_diff = {1'b0, r_rem} - {3'b000, r_div};

    // load operands, then step while the down-counter is non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= i_dividend;
            r_div <= i_divisor;
            r_q   <= '0;
            r_cnt <= 5'(ITER);
        end else if (r_cnt != 5'd0) begin
            if (!w_diff[26]) begin
                r_q   <= {r_q[23:0], 1'b1};
                r_rem <= {w_diff[24:0], 1'b0};
            end else begin
                r_q   <= {r_q[23:0], 1'b0};
                r_rem <= {r_rem[24:0], 1'b0};
            end
            r_cnt <= r_cnt - 5'd1;
        end
    end

    assign o_quotient = r_q;
    assign o_sticky   = (r_rem != 26'd0);
    assign o_busy     = (r_cnt != 5'd0);
    assign o_last     = (r_cnt == 5'd1);
endmodule

// File: rtl/divider32fp.sv
// IEEE-754 single-precision sequential divider, RNE rounding, flush-to-zero.
//  state | meaning
//  IDLE  | waiting for start_i, operands latched on accept
//  CHECK | unpack, resolve special cases, pre-align and load the divider
//  DIV   | restoring divider running, ITER cycles
//  ROUND | round to nearest-even, range check, pack result
module divider32fp
    import fp32_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    divider32fp_if.slave bus
);
    state_t             r_state, w_next;
    fp32_t              r_a, r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [31:0]        r_quot;
    logic               r_done, r_nan, r_inf, r_ovf, r_unf;

    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_is_nan, w_is_inf, w_is_zero, w_normal, w_sign, w_pre;
    logic [23:0]        w_ma, w_mb;
    logic [25:0]        w_dividend;
    logic signed [9:0]  w_exp_chk, w_exp_rnd;
    logic [24:0]        w_q, w_sum;
    logic               w_sticky, w_busy, w_last, w_rnd;
    logic [22:0]        w_frac;

    // subnormals count as zero; NaN has an all-ones exponent with a nonzero fraction
    assign w_a_zero  = (r_a.exp == 8'h00);
    assign w_b_zero  = (r_b.exp == 8'h00);
    assign w_a_inf   = (r_a.exp == 8'hFF) && (r_a.frac == 23'h0);
    assign w_b_inf   = (r_b.exp == 8'hFF) && (r_b.frac == 23'h0);
    assign w_a_nan   = (r_a.exp == 8'hFF) && (r_a.frac != 23'h0);
    assign w_b_nan   = (r_b.exp == 8'hFF) && (r_b.frac != 23'h0);
    assign w_is_nan  = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    assign w_is_inf  = (w_a_inf && !w_b_inf) || (!w_a_zero && w_b_zero);
    assign w_is_zero = w_a_zero || w_b_inf;
    assign w_normal  = !(w_is_nan || w_is_inf || w_is_zero);
    assign w_sign    = r_a.sign ^ r_b.sign;

    // doubling the dividend when ma < mb keeps the quotient in [1,2)
    assign w_ma       = {1'b1, r_a.frac};
    assign w_mb       = {1'b1, r_b.frac};
    assign w_pre      = (w_ma < w_mb);
    assign w_dividend = w_pre ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
    assign w_exp_chk  = $signed({2'b00, r_a.exp}) - $signed({2'b00, r_b.exp})
                      + 10'(EXP_BIAS) - $signed({9'b0, w_pre});

    fp32_mant_divider u_mant (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     ((r_state == CHECK) && w_normal),
        .i_dividend (w_dividend),
        .i_divisor  (w_mb),
        .o_quotient (w_q),
        .o_sticky   (w_sticky),
        .o_busy     (w_busy),
        .o_last     (w_last)
    );

    // q[24:1] is the significand, q[0] the guard bit; a carry-out renormalises
    assign w_rnd     = w_q[0] && (w_sticky || w_q[1]);
    assign w_sum     = {1'b0, w_q[24:1]} + {24'b0, w_rnd};
    assign w_frac    = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_exp_rnd = r_exp + $signed({9'b0, w_sum[24]});

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_i) w_next = CHECK;
            CHECK:   w_next = w_normal ? DIV : IDLE;
            DIV:     if (w_last || !w_busy) w_next = ROUND;
            ROUND:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // operand capture, special-case and rounded result registers, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_quot <= '0;
            r_done <= 1'b0;
            r_nan  <= 1'b0;
            r_inf  <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_a <= bus.a_i;
                        r_b <= bus.b_i;
                    end
                end
                CHECK: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_chk;
                    if (!w_normal) begin
                        r_done <= 1'b1;
                        r_nan  <= w_is_nan;
                        r_inf  <= !w_is_nan && w_is_inf;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        if (w_is_nan)      r_quot <= QNAN;
                        else if (w_is_inf) r_quot <= {w_sign, POS_INF[30:0]};
                        else               r_quot <= {w_sign, 31'h0};
                    end
                end
                ROUND: begin
                    r_done <= 1'b1;
                    r_nan  <= 1'b0;
                    r_inf  <= 1'b0;
                    r_ovf  <= (w_exp_rnd >= 10'sd255);
                    r_unf  <= (w_exp_rnd <= 10'sd0);
                    if (w_exp_rnd >= 10'sd255)  r_quot <= {r_sign, POS_INF[30:0]};
                    else if (w_exp_rnd <= 10'sd0) r_quot <= {r_sign, 31'h0};
                    else                          r_quot <= {r_sign, w_exp_rnd[7:0], w_frac};
                end
                default: ;
            endcase
        end
    end

    assign bus.done_o      = r_done;
    assign bus.nan_o       = r_nan;
    assign bus.infinit_o   = r_inf;
    assign bus.overflow_o  = r_ovf;
    assign bus.underflow_o = r_unf;
    assign bus.quotient_o  = r_quot;
endmodule

// File: tb/tb_divider32fp.sv
// Directed and randomised checks for the sequential FP32 divider.
module tb_divider32fp;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    divider32fp_if bus ();

    divider32fp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags packed as {nan, inf, ovf, unf}
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                          output logic [31:0] q, output logic [3:0] f, output int cyc);
        cyc = -1;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (bus.done_o) begin
                cyc = c;
                break;
            end
            if (c == inj) begin
                bus.start_i = 1'b1;
                bus.a_i     = 32'h40C0_0000;
                bus.b_i     = 32'h4000_0000;
            end
        end
        q = bus.quotient_o;
        f = {bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o};
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int inj, input logic [31:0] exp_q, input logic [3:0] exp_f,
                            input int exp_cyc);
        logic [31:0] q;
        logic [3:0]  f;
        int          cyc;
        run_op(a, b, inj, q, f, cyc);
        check({tag, "_quot"}, 64'(q), 64'(exp_q));
        check({tag, "_flags"}, 64'(f), 64'(exp_f));
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 64'(bus.done_o), 64'd0);
    endtask

    // exact reference: 24-bit quotient by integer division, RNE from the remainder
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, n, q, r;
        int   e;
        logic s;
        logic [31:0] ev;
        s  = a[31] ^ b[31];
        ma = {40'h0, 1'b1, a[22:0]};
        mb = {40'h0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        n  = ma;
        if (ma < mb) begin
            n = n << 1;
            e = e - 1;
        end
        q = (n << 23) / mb;
        r = (n << 23) % mb;
        if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
        if (q == 64'h100_0000) begin
            q = 64'h80_0000;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0010};
        if (e <= 0)   return {s, 31'h0, 4'b0001};
        ev = 32'(e);
        return {s, ev[7:0], q[22:0], 4'b0000};
    endfunction

    initial begin
        logic [31:0] q, a, b;
        logic [3:0]  f;
        int          cyc;
        int          done_cnt;
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk);
        check("reset_quot", 64'(bus.quotient_o), 64'd0);
        check("reset_flags", 64'({bus.done_o, bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o}), 64'd0);
        rst_n = 1'b1;

        directed("six_by_two",   32'h40C0_0000, 32'h4000_0000, 0, 32'h4040_0000, 4'b0000, 27);
        directed("one_by_three", 32'h3F80_0000, 32'h4040_0000, 0, 32'h3EAA_AAAB, 4'b0000, 27);
        directed("neg_six",      32'hC0C0_0000, 32'h4000_0000, 0, 32'hC040_0000, 4'b0000, 27);
        directed("zero_zero",    32'h0000_0000, 32'h0000_0000, 0, 32'h7FC0_0000, 4'b1000, 1);
        directed("div_neg_zero", 32'h3F80_0000, 32'h8000_0000, 0, 32'hFF80_0000, 4'b0100, 1);
        directed("overflow",     32'h7F00_0000, 32'h0080_0000, 0, 32'h7F80_0000, 4'b0010, 27);
        directed("underflow",    32'h0080_0000, 32'h4000_0000, 0, 32'h0000_0000, 4'b0001, 27);
        directed("busy_ignore",  32'h3F80_0000, 32'h4040_0000, 5, 32'h3EAA_AAAB, 4'b0000, 27);
        done_cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done_o) done_cnt++;
        end
        check("busy_ignore_no_extra_done", 64'(done_cnt), 64'd0);

        // reset in the middle of a division
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 32'h3F80_0000;
        bus.b_i     = 32'h4040_0000;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_quot", 64'(bus.quotient_o), 64'd0);
        check("midop_reset_outs", 64'({bus.done_o, bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (bus.done_o) done_cnt++;
        end
        check("midop_reset_no_done", 64'(done_cnt), 64'd0);
        directed("after_reset",  32'h40C0_0000, 32'h4000_0000, 0, 32'h4040_0000, 4'b0000, 27);

        for (int i = 0; i < 1000; i++) begin
            a[31]    = 1'($urandom_range(0, 1));
            b[31]    = 1'($urandom_range(0, 1));
            a[22:0]  = 23'($urandom);
            b[22:0]  = 23'($urandom);
            if (i % 2 == 0) begin
                a[30:23] = 8'($urandom_range(1, 254));
                b[30:23] = 8'($urandom_range(1, 254));
            end else begin
                a[30:23] = 8'($urandom_range(100, 154));
                b[30:23] = 8'($urandom_range(100, 154));
            end
            run_op(a, b, 0, q, f, cyc);
            if (cyc != 27) $error("FAIL rand_latency: observed %0d expected 27", cyc);
            check("rand", {28'h0, q, f}, {28'h0, ref_div(a, b)} | ((cyc != 27) ? 64'h1_0000_0000_0 : 64'h0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
